// File: rtl/uart_str_tx.sv
//============================================================================
// Module   : uart_str_tx
// Purpose  : Sends a string held in a small internal byte buffer as a
//            sequence of back-to-back UART frames. The frame is a start bit,
//            8 data bits (LSB first) and one stop bit, with an optional even
//            parity bit. The string can be sent once or repeated, and a
//            transfer can be aborted at the next character boundary.
// Options  : define UART_STR_TX_PARITY_EN to insert an even-parity bit
//            between data bit 7 and the stop bit (11-bit frames).
// Ports    : clk        rising-edge clock
//            rst        asynchronous active-high reset
//            wr_en      buffer write strobe (ignored while busy)
//            wr_addr    buffer write address
//            wr_data    buffer write byte
//            len        characters to send, sampled on start
//            start      single-cycle request to begin sending
//            repeat_en  resend the string continuously (sampled at pass end)
//            abort      stop after the current character
//            busy       transfer in progress
//            done       one-cycle pulse at the end of each complete pass
//            tx         UART serial line, idle high
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module uart_str_tx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DEPTH        = 16,
  parameter int AW           = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW:0]   len,
  input  logic          start,
  input  logic          repeat_en,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          tx
);

  localparam int            BW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_LEN  = (AW+1)'(DEPTH);

`ifdef UART_STR_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    PARITY    = 3'd3,
    STOP_BIT  = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;
`endif

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [AW-1:0] index;
  logic [AW:0]   len_lat;
  logic          launch;      // first busy cycle: buffer read in flight, line still idle
  logic          abort_flag;

  // String buffer with a synchronous read port. rd_data is the character
  // being shifted out; it is loaded at the edge that starts each frame.
  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic          baud_end;
  logic          pass_end;
  logic          abort_now;
  logic [AW:0]   len_eff;

  assign baud_end  = (baud_cnt == BAUD_LAST);
  // Index of the current character is the last one of the pass.
  assign pass_end  = (({1'b0, index}) + (AW+1)'(1)) == len_lat;
  assign abort_now = abort_flag | abort;
  assign len_eff   = (len > DEPTH_LEN) ? DEPTH_LEN : len;

  // The read is issued on the same edge that drives the start bit, so the
  // byte is ready long before data bit 0 and no idle gap is needed.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = index;
    if (state == START_BIT && launch) begin
      rd_en   = 1'b1;
      rd_addr = index;
    end else if (state == STOP_BIT && baud_end) begin
      rd_en   = 1'b1;
      rd_addr = pass_end ? '0 : index + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      index      <= '0;
      len_lat    <= '0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      launch     <= 1'b0;
      abort_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy && abort) begin
        abort_flag <= 1'b1;
      end

      case (state)
        IDLE: begin
          tx         <= 1'b1;
          launch     <= 1'b0;
          abort_flag <= 1'b0;
          if (busy) begin
            // Trailing cycle after a completed pass: busy drops here and a
            // start arriving in this cycle is still ignored.
            busy <= 1'b0;
          end else if (start) begin
            index    <= '0;
            len_lat  <= len_eff;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            if (len_eff == '0) begin
              done <= 1'b1;
            end else begin
              busy   <= 1'b1;
              launch <= 1'b1;
              state  <= START_BIT;
            end
          end
        end

        START_BIT: begin
          if (launch) begin
            launch <= 1'b0;
            tx     <= 1'b0;
          end else if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= rd_data[0];
            state    <= DATA_BITS;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

        DATA_BITS: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
`ifdef UART_STR_TX_PARITY_EN
              tx    <= ^rd_data;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP_BIT;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= rd_data[bit_cnt + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

`ifdef UART_STR_TX_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP_BIT;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
`endif

        STOP_BIT: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            if (pass_end) begin
              // A finished pass always reports done, even when an abort
              // arrives at the same time; abort only suppresses the repeat.
              done  <= 1'b1;
              index <= '0;
              if (abort_now || !repeat_en) begin
                abort_flag <= 1'b0;
                state      <= IDLE;
              end else begin
                tx    <= 1'b0;
                state <= START_BIT;
              end
            end else if (abort_now) begin
              abort_flag <= 1'b0;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              index <= index + AW'(1);
              tx    <= 1'b0;
              state <= START_BIT;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_str_tx.sv
//============================================================================
// Module   : tb_uart_str_tx
// Purpose  : Self-checking bench for uart_str_tx. A table of transfer
//            scenarios plus randomized strings are compared cycle by cycle
//            against a waveform predicted from the frame rules.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_uart_str_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef UART_STR_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F    = NB * CPB;   // cycles per character
  localparam int MAXW = 800;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic [AW:0]   len = '0;
  logic          start = 1'b0;
  logic          repeat_en = 1'b0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic          tx;

  uart_str_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .start(start), .repeat_en(repeat_en), .abort(abort),
    .busy(busy), .done(done), .tx(tx)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] bufm [DEPTH];     // shadow of what the buffer should hold
  logic [2:0] cap  [MAXW];      // captured {tx,busy,done} per cycle
  logic [2:0] expw [MAXW];      // predicted {tx,busy,done} per cycle

  typedef struct {
    int         len;
    int         passes;
    int         abort_at;
    int         poke_at;
    logic [7:0] b0;
    logic [7:0] b1;
    int         exp_frames;
    int         exp_dones;
  } vec_t;
  vec_t vt [8];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Line level of bit slot k of a frame carrying byte b.
  function automatic logic fbit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NB == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Predict the waveform of one transfer started at relative cycle 0.
  task automatic build_model(input int L, input int passes, input int abort_at);
    int lc, nf, e;
    bit lpe;
    for (int i = 0; i < MAXW; i++) expw[i] = 3'b100;
    lc = (L > DEPTH) ? DEPTH : L;
    if (lc == 0) begin
      expw[1] = 3'b101;
      return;
    end
    nf = passes * lc;
    if (abort_at >= 1) begin
      int ka;
      ka = (abort_at < 2) ? 0 : (abort_at - 2) / F;
      if (ka + 1 < nf) nf = ka + 1;
    end
    e   = 2 + nf * F;
    lpe = ((nf - 1) % lc) == (lc - 1);
    for (int t = 1; t < e + (lpe ? 1 : 0); t++) expw[t][1] = 1'b1;
    for (int k = 0; k < nf; k++) begin
      for (int b = 0; b < NB; b++)
        for (int c = 0; c < CPB; c++)
          expw[2 + k*F + b*CPB + c][2] = fbit(bufm[k % lc], b);
      if (k % lc == lc - 1) expw[2 + (k+1)*F][0] = 1'b1;
    end
  endtask

  task automatic load(input int a, input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    bufm[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Run one transfer and compare it against the model. poke_at issues a
  // start and a buffer write while busy; both must have no effect.
  task automatic run_case(input int L, input int passes, input int abort_at,
                          input int poke_at, input string name,
                          output int frames, output int dones);
    int lc, drop, win, first_bad, t;
    lc   = (L > DEPTH) ? DEPTH : L;
    build_model(L, passes, abort_at);
    win  = 2 + passes * lc * F + 6;
    drop = 2 + (passes - 1) * lc * F + 3;
    for (int i = 0; i < win; i++) begin
      @(negedge clk);
      cap[i]    = {tx, busy, done};
      start     = (i == 0) || (i == poke_at);
      len       = (i == 0) ? (AW+1)'(L) : ((i == poke_at) ? (AW+1)'(7) : '1);
      repeat_en = (passes > 1) && (i < drop);
      abort     = (i == abort_at);
      wr_en     = (i == poke_at);
      wr_addr   = '0;
      wr_data   = ~bufm[0];
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; wr_en = 1'b0; repeat_en = 1'b0; len = '0;

    first_bad = -1;
    for (int i = 0; i < win; i++)
      if (first_bad < 0 && cap[i] !== expw[i]) first_bad = i;
    total++;
    if (first_bad >= 0) begin
      bad++;
      $display("FAIL %s waveform: cycle %0d got {tx,busy,done}=%b expected %b",
               name, first_bad, cap[first_bad], expw[first_bad]);
    end

    frames = 0;
    dones  = 0;
    t = 0;
    while (t < win) begin
      if (cap[t][2] == 1'b0) begin
        frames++;
        t += F;
      end else begin
        t++;
      end
    end
    for (int i = 0; i < win; i++) if (cap[i][0]) dones++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fr, dn;

    vt[0] = '{2, 1, -1,          50, 8'h68, 8'h69, 2,  1};  // "hi"
    vt[1] = '{0, 1, -1,          -1, 8'h61, 8'h62, 0,  1};  // empty string
    vt[2] = '{3, 3, -1,          -1, 8'h61, 8'h62, 9,  3};  // "abc" repeated
    vt[3] = '{5, 1, 2 + F + 10,  -1, 8'h07, 8'h03, 2,  0};  // abort in char 1
    vt[4] = '{20, 1, -1,         -1, 8'h61, 8'h62, 16, 1};  // len clamps to DEPTH
    vt[5] = '{1, 1, -1,          10, 8'h07, 8'h62, 1,  1};  // single char
    vt[6] = '{3, 1, 2 + 2*F + 5, -1, 8'h03, 8'h5A, 3,  1};  // abort in last char
    vt[7] = '{2, 2, 2 + 2*F + 3, -1, 8'hFF, 8'h00, 3,  1};  // abort in 2nd pass

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset tx", tx, 1);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) load(i, 8'(8'h61 + i));

    for (int i = 0; i < 8; i++) begin
      load(0, vt[i].b0);
      load(1, vt[i].b1);
      run_case(vt[i].len, vt[i].passes, vt[i].abort_at, vt[i].poke_at,
               $sformatf("vec%0d", i), fr, dn);
      check($sformatf("vec%0d frames", i), fr, vt[i].exp_frames);
      check($sformatf("vec%0d dones", i), dn, vt[i].exp_dones);
      if (i == 0) begin
        check("hi tx idle in cycle 1", cap[1][2], 1);
        check("hi tx low in cycle 2", cap[2][2], 0);
        check("hi done at pass end", cap[2 + 2*F][0], 1);
        check("hi busy at done", cap[2 + 2*F][1], 1);
        check("hi busy after done", cap[3 + 2*F][1], 0);
      end
    end

    // Reset in the middle of data bit 3 of 0xA5 (bit 3 is 0).
    load(0, 8'hA5);
    @(negedge clk);
    start = 1'b1;
    len   = (AW+1)'(1);
    @(negedge clk);
    start = 1'b0;
    len   = '0;
    repeat (17) @(negedge clk);
    check("mid-frame tx before reset", tx, 0);
    rst = 1'b1;
    #1;
    check("mid-frame reset tx", tx, 1);
    check("mid-frame reset busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    run_case(1, 1, -1, -1, "after reset", fr, dn);
    check("after reset frames", fr, 1);

    // Random strings, lengths, repeat and abort points.
    for (int r = 0; r < 6; r++) begin
      int L, P, A;
      for (int i = 0; i < DEPTH; i++) load(i, 8'($urandom));
      L = $urandom_range(1, 6);
      P = $urandom_range(1, 2);
      A = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 + P*L*F - 1) : -1;
      run_case(L, P, A, -1, $sformatf("rand%0d", r), fr, dn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
